// File: rtl/freq_lock_controller.sv
// Frequency acquisition FSM: confirms a stable class from the classifier, tracks lock loss, watchdog and retry limit.
// All outputs registered; a class is evaluated one cycle after done_tick; no backpressure (start is ignored while busy).
module freq_lock_controller #(
    parameter int unsigned CONFIRM_N   = 3,
    parameter int unsigned LOSS_N      = 2,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned MAX_TRIES   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        done_tick,
    input  logic [15:0] prd2,
    input  logic        is_5M,
    input  logic        is_10M,
    input  logic        is_20M,
    output logic        meas_en,
    output logic        busy,
    output logic        locked,
    output logic [1:0]  lock_class,
    output logic        lock_pulse,
    output logic        loss_pulse,
    output logic        timeout,
    output logic        fail,
    output logic [15:0] last_prd
);
    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED, S_FAIL} state_t;

    localparam logic [3:0]  CONFIRM_L = 4'(CONFIRM_N);
    localparam logic [3:0]  LOSS_L    = 4'(LOSS_N);
    localparam logic [7:0]  TRIES_L   = 8'(MAX_TRIES);
    localparam logic [15:0] WD_LAST   = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  match_q, match_d, miss_q, miss_d;
    logic [7:0]  try_q, try_d;
    logic [15:0] wd_q, wd_d, prd_q, prd_d;
    logic [1:0]  prev_q, prev_d, cls_q, cls_d;
    logic        pend_q, pend_d, lp_q, lp_d, loss_q, loss_d, to_q, to_d, fail_q, fail_d;
    logic        busy_q, lock_q;
    logic [1:0]  cls;
    logic [3:0]  match_nx, miss_nx;
    logic [7:0]  try_nx;

    always_comb begin
        cls = 2'b00;
        case ({is_5M, is_10M, is_20M})
            3'b100:  cls = 2'b01;
            3'b010:  cls = 2'b10;
            3'b001:  cls = 2'b11;
            default: cls = 2'b00;
        endcase
    end

    assign match_nx = (cls == 2'b00) ? 4'd0 : ((cls == prev_q) ? match_q + 4'd1 : 4'd1);
    assign miss_nx  = miss_q + 4'd1;
    assign try_nx   = try_q + 8'd1;

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        miss_d  = miss_q;
        try_d   = try_q;
        prev_d  = prev_q;
        cls_d   = cls_q;
        wd_d    = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
        pend_d  = 1'b0;
        lp_d    = 1'b0;
        loss_d  = 1'b0;
        to_d    = to_q;
        fail_d  = fail_q;
        prd_d   = done_tick ? prd2 : prd_q;
        if (stop) begin
            state_d = S_IDLE;
            match_d = '0;
            miss_d  = '0;
            try_d   = '0;
            wd_d    = '0;
            prev_d  = '0;
            cls_d   = '0;
            to_d    = 1'b0;
            fail_d  = 1'b0;
            prd_d   = prd_q;
        end else begin
            case (state_q)
                S_MEASURE: begin
                    pend_d = done_tick;
                    if (done_tick) wd_d = '0;
                    if (pend_q) begin
                        prev_d  = cls;
                        try_d   = try_nx;
                        match_d = match_nx;
                        if (match_nx == CONFIRM_L) begin
                            state_d = S_LOCKED;
                            cls_d   = cls;
                            lp_d    = 1'b1;
                            miss_d  = '0;
                            wd_d    = '0;
                        end else if (try_nx == TRIES_L) begin
                            state_d = S_FAIL;
                            fail_d  = 1'b1;
                        end
                    end
                    // An evaluation-driven transition outranks the watchdog on the same edge.
                    if (state_d == S_MEASURE && !done_tick && wd_q == WD_LAST) begin
                        state_d = S_FAIL;
                        to_d    = 1'b1;
                    end
                end
                S_LOCKED: begin
                    pend_d = done_tick;
                    if (done_tick) wd_d = '0;
                    if (pend_q) begin
                        if (cls == cls_q) begin
                            miss_d = '0;
                        end else if (miss_nx == LOSS_L) begin
                            state_d = S_MEASURE;
                            cls_d   = '0;
                            loss_d  = 1'b1;
                            match_d = '0;
                            miss_d  = '0;
                            try_d   = '0;
                            wd_d    = '0;
                            prev_d  = '0;
                        end else begin
                            miss_d = miss_nx;
                        end
                    end
                    if (state_d == S_LOCKED && !done_tick && wd_q == WD_LAST) begin
                        state_d = S_FAIL;
                        to_d    = 1'b1;
                        cls_d   = '0;
                        loss_d  = 1'b1;
                    end
                end
                default: begin
                    wd_d = '0;
                    if (start) begin
                        state_d = S_MEASURE;
                        match_d = '0;
                        miss_d  = '0;
                        try_d   = '0;
                        prev_d  = '0;
                        to_d    = 1'b0;
                        fail_d  = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            match_q <= '0;
            miss_q  <= '0;
            try_q   <= '0;
            wd_q    <= '0;
            prev_q  <= '0;
            cls_q   <= '0;
            pend_q  <= 1'b0;
            lp_q    <= 1'b0;
            loss_q  <= 1'b0;
            to_q    <= 1'b0;
            fail_q  <= 1'b0;
            prd_q   <= '0;
            busy_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            try_q   <= try_d;
            wd_q    <= wd_d;
            prev_q  <= prev_d;
            cls_q   <= cls_d;
            pend_q  <= pend_d;
            lp_q    <= lp_d;
            loss_q  <= loss_d;
            to_q    <= to_d;
            fail_q  <= fail_d;
            prd_q   <= prd_d;
            busy_q  <= (state_d == S_MEASURE) || (state_d == S_LOCKED);
            lock_q  <= (state_d == S_LOCKED);
        end
    end

    assign meas_en    = busy_q;
    assign busy       = busy_q;
    assign locked     = lock_q;
    assign lock_class = cls_q;
    assign lock_pulse = lp_q;
    assign loss_pulse = loss_q;
    assign timeout    = to_q;
    assign fail       = fail_q;
    assign last_prd   = prd_q;
endmodule

// File: tb/tb_freq_lock_controller.sv
// Bench for freq_lock_controller: directed scenarios then random traffic, every cycle compared
// against an event-history reference model.
module tb_freq_lock_controller;
    localparam int CONFIRM_N   = 3;
    localparam int LOSS_N      = 2;
    localparam int TIMEOUT_CYC = 1000;
    localparam int MAX_TRIES   = 16;

    logic        clk = 1'b0;
    logic        reset, start, stop, done_tick;
    logic [15:0] prd2;
    logic        is_5M, is_10M, is_20M;
    logic        meas_en, busy, locked, lock_pulse, loss_pulse, timeout, fail;
    logic [1:0]  lock_class;
    logic [15:0] last_prd;

    freq_lock_controller #(
        .CONFIRM_N(CONFIRM_N), .LOSS_N(LOSS_N), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .done_tick(done_tick), .prd2(prd2),
        .is_5M(is_5M), .is_10M(is_10M), .is_20M(is_20M), .meas_en(meas_en), .busy(busy),
        .locked(locked), .lock_class(lock_class), .lock_pulse(lock_pulse), .loss_pulse(loss_pulse),
        .timeout(timeout), .fail(fail), .last_prd(last_prd)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cycle_n = 0;

    // Model: mode 0 idle, 1 measure, 2 locked, 3 fail. hist holds classifications
    // since acquisition began (in measure) or consecutive misses (in locked).
    int          mst = 0;
    int          hist[$];
    int          lk = 0;
    bit          pend = 0;
    int          quiet = 0;
    bit          m_lp = 0, m_loss = 0, m_to = 0, m_fail = 0;
    logic [15:0] m_prd = '0;
    bit          got_lp, got_loss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [2:0] f);
        if ($countones(f) != 1) return 0;
        if (f[2]) return 1;
        if (f[1]) return 2;
        return 3;
    endfunction

    function automatic logic [2:0] c2f(input int code);
        case (code)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            4:       return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit tail_locks(input int c);
        if (c == 0 || hist.size() < CONFIRM_N) return 1'b0;
        for (int i = hist.size() - CONFIRM_N; i < hist.size(); i++)
            if (hist[i] != c) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        int prev_st;
        int c;
        m_lp = 0;
        m_loss = 0;
        if (reset) begin
            mst = 0; hist.delete(); lk = 0; pend = 0; quiet = 0;
            m_to = 0; m_fail = 0; m_prd = '0;
        end else if (stop) begin
            mst = 0; hist.delete(); lk = 0; pend = 0; quiet = 0;
            m_to = 0; m_fail = 0;
        end else if (mst == 0 || mst == 3) begin
            if (done_tick) m_prd = prd2;
            if (start) begin
                mst = 1; hist.delete(); m_to = 0; m_fail = 0; quiet = 0; pend = 0;
            end
        end else begin
            prev_st = mst;
            if (done_tick) m_prd = prd2;
            if (pend) begin
                c = decode({is_5M, is_10M, is_20M});
                hist.push_back(c);
                if (mst == 1) begin
                    if (tail_locks(c)) begin
                        mst = 2; lk = c; m_lp = 1; hist.delete();
                    end else if (hist.size() == MAX_TRIES) begin
                        mst = 3; m_fail = 1;
                    end
                end else if (c == lk) begin
                    hist.delete();
                end else if (hist.size() == LOSS_N) begin
                    mst = 1; lk = 0; m_loss = 1; hist.delete();
                end
            end
            if (mst != prev_st || done_tick) quiet = 0;
            else begin
                quiet++;
                if (quiet >= TIMEOUT_CYC) begin
                    if (mst == 2) m_loss = 1;
                    mst = 3; lk = 0; m_to = 1;
                end
            end
            pend = done_tick && (mst == 1 || mst == 2);
        end
    endtask

    task automatic cyc();
        logic busy_e;
        @(posedge clk);
        #1;
        model_step();
        cycle_n++;
        busy_e = (mst == 1 || mst == 2);
        chk($sformatf("outputs@cycle%0d", cycle_n),
            {7'd0, meas_en, busy, locked, lock_class, lock_pulse, loss_pulse, timeout, fail, last_prd},
            {7'd0, busy_e, busy_e, (mst == 2), 2'(lk), m_lp, m_loss, m_to, m_fail, m_prd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            done_tick = 1'b0;
            {is_5M, is_10M, is_20M} = 3'($urandom_range(0, 7));
            cyc();
        end
    endtask

    // One measurement: done_tick cycle, then the class flags in the evaluation cycle.
    task automatic meas(input int code);
        done_tick = 1'b1;
        prd2 = 16'($urandom);
        {is_5M, is_10M, is_20M} = 3'($urandom_range(0, 7));
        cyc();
        done_tick = 1'b0;
        {is_5M, is_10M, is_20M} = c2f(code);
        cyc();
        got_lp = lock_pulse;
        got_loss = loss_pulse;
        {is_5M, is_10M, is_20M} = 3'b000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        bit any_lp;
        int tgt;
        reset = 1'b1; start = 1'b0; stop = 1'b0; done_tick = 1'b0; prd2 = '0;
        {is_5M, is_10M, is_20M} = 3'b000;
        cyc(); cyc();
        chk("reset_outputs", {7'd0, meas_en, busy, locked, lock_class, lock_pulse, loss_pulse,
                              timeout, fail, last_prd}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Three 10 MHz classifications lock on the third evaluation.
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        meas(2); chk("lock_early1", 32'(got_lp), 32'd0);
        meas(2); chk("lock_early2", 32'(got_lp), 32'd0);
        meas(2); chk("lock_pulse_10M", 32'(got_lp), 32'd1);
        chk("lock_class_10M", 32'(lock_class), 32'd2);
        chk("locked_10M", 32'(locked), 32'd1);
        idle(1);
        chk("lock_pulse_single", 32'(lock_pulse), 32'd0);

        // A single miss keeps lock; two consecutive misses drop it.
        meas(1); meas(2);
        chk("single_miss_keeps", 32'(locked), 32'd1);
        meas(1); chk("first_miss_no_loss", 32'(got_loss), 32'd0);
        meas(1); chk("loss_pulse", 32'(got_loss), 32'd1);
        chk("loss_unlocked", 32'(locked), 32'd0);
        chk("loss_still_busy", 32'(busy), 32'd1);
        chk("loss_class_none", 32'(lock_class), 32'd0);

        // 10,10,20,20,20 locks on the fifth evaluation at 20 MHz.
        any_lp = 0;
        meas(2); any_lp |= got_lp;
        meas(2); any_lp |= got_lp;
        meas(3); any_lp |= got_lp;
        meas(3); any_lp |= got_lp;
        chk("no_early_lock", 32'(any_lp), 32'd0);
        meas(3); chk("lock_pulse_20M", 32'(got_lp), 32'd1);
        chk("lock_class_20M", 32'(lock_class), 32'd3);

        stop = 1'b1; cyc(); stop = 1'b0;
        chk("stop_idle", {24'd0, meas_en, busy, locked, lock_class, lock_pulse, timeout, fail}, 32'd0);

        // Watchdog: no done_tick for TIMEOUT_CYC cycles.
        pulse_start();
        idle(TIMEOUT_CYC - 1);
        chk("no_timeout_yet", 32'(timeout), 32'd0);
        idle(1);
        chk("timeout_set", {28'd0, timeout, fail, meas_en, busy}, 32'b1000);
        idle(3);
        chk("timeout_sticky", 32'(timeout), 32'd1);
        pulse_start();
        chk("start_clears_timeout", {30'd0, timeout, busy}, 32'b01);

        // Alternating classes never lock and exhaust the tries.
        any_lp = 0;
        for (int i = 0; i < MAX_TRIES; i++) begin
            if (i == MAX_TRIES - 1) chk("fail_not_yet", 32'(fail), 32'd0);
            meas((i % 2 == 0) ? 1 : 2);
            any_lp |= got_lp;
        end
        chk("fail_set", {29'd0, fail, busy, locked}, 32'b100);
        chk("fail_no_lock", 32'(any_lp), 32'd0);

        // Reset in the middle of acquisition.
        pulse_start();
        meas(2); meas(2);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("mid_reset", {7'd0, meas_en, busy, locked, lock_class, lock_pulse, loss_pulse,
                          timeout, fail, last_prd}, 32'd0);
        idle(1);

        // Stop coincident with the done_tick that would have confirmed lock.
        pulse_start();
        meas(2); meas(2);
        stop = 1'b1; done_tick = 1'b1; prd2 = 16'($urandom); cyc();
        stop = 1'b0; done_tick = 1'b0; {is_5M, is_10M, is_20M} = 3'b010;
        chk("stop_done_idle", {24'd0, meas_en, busy, locked, lock_class, lock_pulse, timeout, fail}, 32'd0);
        cyc();
        chk("stop_done_no_lock", {30'd0, lock_pulse, locked}, 32'd0);

        // Random traffic against the model.
        tgt = 2;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            stop = ($urandom_range(0, 249) == 0);
            start = ($urandom_range(0, 24) == 0);
            done_tick = ($urandom_range(0, 2) == 0);
            prd2 = 16'($urandom);
            if ($urandom_range(0, 11) == 0) tgt = $urandom_range(0, 4);
            {is_5M, is_10M, is_20M} = c2f(tgt);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
